// File: rtl/rf_wport_arbiter_pkg.sv
// ============================================================================
// Module   : rf_wport_arbiter_pkg
// Purpose  : Shared types and constants for the register-file write-port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rf_wport_arbiter_pkg;

    localparam int RF_ARB_MAX_WAIT = 4;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
        logic        live;
    } rf_wreq_t;

    typedef enum logic [0:0] {
        S_NORMAL = 1'b0,
        S_FORCE  = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_wport_arbiter_fifo.sv
// ============================================================================
// Module   : rf_wreq_fifo
// Purpose  : Long-latency return buffer with parallel destination kill (WAW).
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_wreq_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_push,
    input  logic [4:0]  i_push_dst,
    input  logic [31:0] i_push_data,
    input  logic        i_pop,
    input  logic        i_flush,
    input  logic        i_kill_en,
    input  logic [4:0]  i_kill_dst,
    output rf_wreq_t    o_head,
    output logic        o_empty,
    output logic        o_full
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_cw-1:0] r_count;
    rf_wreq_t        r_mem [DEPTH];
    logic            w_push_live;

    // r0 writes and results superseded by a same-cycle pipeline write are stored dead
    assign w_push_live = (i_push_dst != 5'd0) &&
                         !(i_kill_en && (i_kill_dst == i_push_dst));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && (r_wptr == c_aw'(i))) begin
                    r_mem[i] <= '{dst: i_push_dst, data: i_push_data, live: w_push_live};
                end else if (i_kill_en && (r_mem[i].dst == i_kill_dst)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + c_cw'(i_push) - c_cw'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_cw'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/rf_wport_arbiter.sv
// ============================================================================
// Module   : rf_wport_arbiter
// Purpose  : Shares the GPR write port between WB and long-latency returns.
//            Optional zero-latency bypass when RF_ARB_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = RF_ARB_MAX_WAIT,
    parameter int DEPTH    = 2
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic        wb_dis,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] wb_data,
    input  logic        lr_valid,
    output logic        lr_ready,
    input  logic [4:0]  lr_dst,
    input  logic [31:0] lr_data,
    input  logic        lr_flush,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        lr_pending
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_nxt;
    logic [3:0] w_wait_inc;
    logic       w_pipe_eff;
    logic       w_head_live;
    logic       w_head_dead;
    logic       w_grant_pipe;
    logic       w_grant_head;
    logic       w_grant_byp;
    logic       w_pop;
    logic       w_push;
    logic       w_empty;
    logic       w_full;
    rf_wreq_t   w_head;

    rf_wreq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_push_dst  (lr_dst),
        .i_push_data (lr_data),
        .i_pop       (w_pop),
        .i_flush     (lr_flush),
        .i_kill_en   (w_grant_pipe),
        .i_kill_dst  (wb_dst),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    assign w_pipe_eff  = wb_valid && !wb_dis && (wb_dst != 5'd0);
    assign w_head_live = !w_empty && w_head.live;
    assign w_head_dead = !w_empty && !w_head.live;
    assign w_wait_inc  = (r_wait_cnt == 4'hF) ? r_wait_cnt : r_wait_cnt + 4'd1;

    assign lr_ready    = !w_full;
    assign lr_pending  = !w_empty;
    assign pipe_stall  = (r_state == S_FORCE) && w_head_live;
    assign w_push      = lr_valid && lr_ready && !lr_flush && !w_grant_byp;

    always_comb begin
        w_grant_pipe = 1'b0;
        w_grant_head = 1'b0;
        w_grant_byp  = 1'b0;
        w_pop        = 1'b0;
        w_state_nxt  = S_NORMAL;
        w_wait_nxt   = 4'd0;
        case (r_state)
            S_NORMAL: begin
                if (w_pipe_eff) begin
                    w_grant_pipe = 1'b1;
                end else if (w_head_live && !lr_flush) begin
                    w_grant_head = 1'b1;
                end
`ifdef RF_ARB_BYPASS_EN
                else if (w_empty && lr_valid && !lr_flush && (lr_dst != 5'd0)) begin
                    w_grant_byp = 1'b1;
                end
`endif
                w_pop = w_grant_head || w_head_dead;
                if (w_pipe_eff && w_head_live) begin
                    w_wait_nxt = w_wait_inc;
                    if (w_wait_inc >= c_max_wait) begin
                        w_state_nxt = S_FORCE;
                    end
                end
            end
            S_FORCE: begin
                // A head killed meanwhile needs no stall; WB proceeds normally
                if (w_head_live) begin
                    w_grant_head = !lr_flush;
                    w_pop        = !lr_flush;
                end else begin
                    w_grant_pipe = w_pipe_eff;
                    w_pop        = w_head_dead;
                end
            end
            default: begin
                w_state_nxt = S_NORMAL;
            end
        endcase
        if (lr_flush) begin
            w_state_nxt = S_NORMAL;
            w_wait_nxt  = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_NORMAL;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (w_grant_pipe) begin
            rf_we    = 1'b1;
            rf_waddr = wb_dst;
            rf_wdata = wb_data;
        end else if (w_grant_head) begin
            rf_we    = 1'b1;
            rf_waddr = w_head.dst;
            rf_wdata = w_head.data;
        end else if (w_grant_byp) begin
            rf_we    = 1'b1;
            rf_waddr = lr_dst;
            rf_wdata = lr_data;
        end
    end

endmodule

`default_nettype wire
